// File: rtl/gf_mac_pipe_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gf_pkg: shared GF(2^M) types, defaults and carry-less helpers for gf_mac_pipe.
// Rev 1.0
// ----------------------------------------------------------------------------
package gf_pkg;

  localparam int          GF_M_DEFAULT    = 8;
  localparam int unsigned GF_POLY_DEFAULT = 32'h11D;
  localparam int          GF_MAX_M        = 16;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MAC    = 2'd1,
    HORNER = 2'd2,
    RSVD   = 2'd3
  } gf_mode_e;

  typedef logic [GF_MAX_M-1:0]   gf_sym_t;
  typedef logic [2*GF_MAX_M-2:0] gf_prod_t;
  typedef logic [GF_MAX_M:0]     gf_poly_t;

  function automatic gf_prod_t gf_clmul(input gf_sym_t a, input gf_sym_t b);
    gf_prod_t p;
    p = '0;
    for (int i = 0; i < GF_MAX_M; i++) begin
      if (b[i]) p = p ^ (gf_prod_t'(a) << i);
    end
    return p;
  endfunction

  // Long division from the top bit down; bits at or above m end up cleared.
  function automatic gf_sym_t gf_reduce(input gf_prod_t p, input gf_poly_t poly, input int m);
    gf_prod_t r;
    r = p;
    for (int i = 2*GF_MAX_M-2; i >= 0; i--) begin
      if ((i >= m) && r[i]) r = r ^ (gf_prod_t'(poly) << (i - m));
    end
    return r[GF_MAX_M-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/gf_mac_pipe_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gf_mac_pipe_if: operand/result handshake bundle for gf_mac_pipe.
// Rev 1.0
// ----------------------------------------------------------------------------
interface gf_mac_pipe_if #(
  parameter int M = gf_pkg::GF_M_DEFAULT
);
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] in_a;
  logic [M-1:0] in_b;
  logic [1:0]   in_mode;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] out_y;
  logic         busy;

  modport master (
    output in_valid, in_a, in_b, in_mode, in_last, out_ready,
    input  in_ready, out_valid, out_y, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, in_last, out_ready,
    output in_ready, out_valid, out_y, busy
  );
endinterface
`default_nettype wire

// File: rtl/gf_mac_pipe_mul.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gf_mul_comb: combinational (a*b ^ c) mod POLY over GF(2^M); c is unreduced.
// Rev 1.0
// ----------------------------------------------------------------------------
module gf_mul_comb import gf_pkg::*; #(
  parameter int          M    = GF_M_DEFAULT,
  parameter int unsigned POLY = GF_POLY_DEFAULT
) (
  input  logic [M-1:0]   a_i,
  input  logic [M-1:0]   b_i,
  input  logic [2*M-2:0] c_i,
  output logic [M-1:0]   p_o
);
  localparam gf_poly_t POLY_W = gf_poly_t'(POLY);

  always_comb begin
    p_o = M'(gf_reduce(gf_clmul(gf_sym_t'(a_i), gf_sym_t'(b_i)) ^ gf_prod_t'(c_i), POLY_W, M));
  end
endmodule
`default_nettype wire

// File: rtl/gf_mac_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gf_mac_pipe: 2-stage GF(2^M) MUL/MAC pipe; HORNER mode only with GF_MAC_HORNER_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
module gf_mac_pipe import gf_pkg::*; #(
  parameter int          M    = GF_M_DEFAULT,
  parameter int unsigned POLY = GF_POLY_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  gf_mac_pipe_if.slave    bus
);
  localparam int       PW     = 2*M-1;
  localparam gf_poly_t POLY_W = gf_poly_t'(POLY);

  if ((M < 3) || (M > GF_MAX_M)) begin : g_bad_m
    $error("gf_mac_pipe: M must lie in 3..16");
  end
  if (POLY_W[M] != 1'b1) begin : g_bad_poly
    $error("gf_mac_pipe: POLY bit M must be set");
  end

  logic          s1_valid_q, s1_valid_d;
  logic [PW-1:0] s1_prod_q,  s1_prod_d;
  logic [M-1:0]  s1_a_q,     s1_a_d;
  logic [M-1:0]  s1_b_q,     s1_b_d;
  gf_mode_e      s1_mode_q,  s1_mode_d;
  logic          s1_last_q,  s1_last_d;
  logic [M-1:0]  acc_q,      acc_d;
  logic [M-1:0]  out_y_q,    out_y_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q,     busy_d;
  logic          grp_open_q, grp_open_d;
  gf_mode_e      grp_mode_q, grp_mode_d;

  logic          adv, accept, retire, emit;
  gf_mode_e      req_mode, eff_mode;
  logic [M-1:0]  red_y, stage_y;

  // One shared advance: the output register gates every stage.
  assign adv           = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = !reset && adv;
  assign accept        = bus.in_valid && bus.in_ready;
  assign retire        = adv && s1_valid_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;
  assign bus.busy      = busy_q;

  gf_mul_comb #(.M(M), .POLY(POLY)) u_reduce (
    .a_i ('0),
    .b_i ('0),
    .c_i (s1_prod_q),
    .p_o (red_y)
  );

`ifdef GF_MAC_HORNER_EN
  logic [M-1:0] horner_y;

  gf_mul_comb #(.M(M), .POLY(POLY)) u_horner (
    .a_i (acc_q),
    .b_i (s1_b_q),
    .c_i (PW'(s1_a_q)),
    .p_o (horner_y)
  );
`else
  logic unused_ab;
  assign unused_ab = ^{s1_a_q, s1_b_q};
`endif

  always_comb begin
    req_mode = gf_mode_e'(bus.in_mode);
    if (req_mode == RSVD) req_mode = MUL;
`ifndef GF_MAC_HORNER_EN
    if (req_mode == HORNER) req_mode = MUL;
`endif
    eff_mode = grp_open_q ? grp_mode_q : req_mode;

    case (s1_mode_q)
      MAC:     stage_y = acc_q ^ red_y;
`ifdef GF_MAC_HORNER_EN
      HORNER:  stage_y = horner_y;
`endif
      default: stage_y = red_y;
    endcase
    emit = (s1_mode_q == MUL) || s1_last_q;
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_prod_d   = s1_prod_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_mode_d   = s1_mode_q;
    s1_last_d   = s1_last_q;
    acc_d       = acc_q;
    out_y_d     = out_y_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    grp_open_d  = grp_open_q;
    grp_mode_d  = grp_mode_q;

    if (accept && (eff_mode != MUL)) begin
      grp_open_d = !bus.in_last;
      grp_mode_d = bus.in_last ? MUL : eff_mode;
    end

    if (adv) begin
      s1_valid_d  = accept;
      out_valid_d = s1_valid_q && emit;
      if (accept) begin
        s1_prod_d = PW'(gf_clmul(gf_sym_t'(bus.in_a), gf_sym_t'(bus.in_b)));
        s1_a_d    = bus.in_a;
        s1_b_d    = bus.in_b;
        s1_mode_d = eff_mode;
        s1_last_d = bus.in_last;
      end
    end

    if (retire) begin
      if (s1_mode_q != MUL) acc_d = s1_last_q ? '0 : stage_y;
      if (emit) out_y_d = stage_y;
    end

    // A new group opening wins over the old one retiring in the same cycle.
    if (accept && (eff_mode != MUL) && !bus.in_last) begin
      busy_d = 1'b1;
    end else if (retire && (s1_mode_q != MUL) && s1_last_q) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_prod_q   <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_mode_q   <= MUL;
      s1_last_q   <= 1'b0;
      acc_q       <= '0;
      out_y_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      grp_open_q  <= 1'b0;
      grp_mode_q  <= MUL;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_prod_q   <= s1_prod_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_mode_q   <= s1_mode_d;
      s1_last_q   <= s1_last_d;
      acc_q       <= acc_d;
      out_y_q     <= out_y_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      grp_open_q  <= grp_open_d;
      grp_mode_q  <= grp_mode_d;
    end
  end
endmodule
`default_nettype wire
